// File: rtl/dmem_bridge.sv
// Load/store bridge: turns the execute stage's held request into word-aligned bus beats with strobes.
// Optional macro MISALIGN_SPLIT_EN splits word-crossing accesses into two beats instead of rejecting them.
module dmem_bridge #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic [XLEN-1:0] mem_data_i,
    input  logic [1:0]      byte_size_i,
    input  logic            mem_read_en_i,
    input  logic            mem_write_en_i,
    output logic [XLEN-1:0] mem_data_in_o,
    output logic            mem_read_ready_o,
    output logic            mem_write_ready_o,
    output logic            mem_misalign_o,
    output logic            bus_req_o,
    output logic            bus_we_o,
    output logic [XLEN-1:0] bus_addr_o,
    output logic [XLEN-1:0] bus_wdata_o,
    output logic [3:0]      bus_wstrb_o,
    input  logic            bus_ack_i,
    input  logic [XLEN-1:0] bus_rdata_i
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_e;

    function automatic logic [2:0] nbytes(input logic [1:0] sz);
        case (sz)
            2'd1:    nbytes = 3'd1;
            2'd2:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] mask(input logic [1:0] sz);
        case (sz)
            2'd1:    mask = 4'b0001;
            2'd2:    mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
    endfunction

    // Right-justify the addressed bytes of the {hi, lo} pair and zero the rest.
    function automatic logic [XLEN-1:0] extract(input logic [2*XLEN-1:0] hl,
                                                input logic [1:0] off, input logic [1:0] sz);
        logic [XLEN-1:0] sh;
        sh = XLEN'(hl >> {off, 3'b000});
        case (sz)
            2'd1:    extract = sh & XLEN'(32'h0000_00FF);
            2'd2:    extract = sh & XLEN'(32'h0000_FFFF);
            default: extract = sh;
        endcase
    endfunction

    state_e          state_q, state_d;
    logic [1:0]      off_q, off_d;
    logic [1:0]      size_q, size_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            bus_req_q, bus_req_d;
    logic            bus_we_q, bus_we_d;
    logic [XLEN-1:0] bus_addr_q, bus_addr_d;
    logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]      bus_wstrb_q, bus_wstrb_d;
`ifdef MISALIGN_SPLIT_EN
    logic [XLEN-1:0] data_q, data_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            cross_q, cross_d;
`else
    logic            err_q, err_d;
`endif

    logic [1:0] in_off;
    logic       in_cross;
    logic       in_req;
    assign in_off   = mem_addr_i[1:0];
    assign in_cross = ({1'b0, in_off} + nbytes(byte_size_i)) > 3'd4;
    assign in_req   = mem_read_en_i || mem_write_en_i;

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        size_d      = size_q;
        we_d        = we_q;
        rdata_d     = rdata_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
`ifdef MISALIGN_SPLIT_EN
        data_d      = data_q;
        lo_d        = lo_q;
        cross_d     = cross_q;
`else
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_req) begin
                    off_d  = in_off;
                    size_d = byte_size_i;
                    we_d   = !mem_read_en_i;
`ifdef MISALIGN_SPLIT_EN
                    data_d  = mem_data_i;
                    cross_d = in_cross;
`else
                    err_d   = in_cross;
                    if (in_cross) begin
                        state_d = RESP;
                        if (mem_read_en_i) rdata_d = '0;
                    end else
`endif
                    begin
                        state_d     = BEAT0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = !mem_read_en_i;
                        bus_addr_d  = {mem_addr_i[XLEN-1:2], 2'b00};
                        bus_wstrb_d = 4'(mask(byte_size_i) << in_off);
                        bus_wdata_d = mem_data_i << {in_off, 3'b000};
                    end
                end
            end
            BEAT0: begin
                if (bus_ack_i) begin
`ifdef MISALIGN_SPLIT_EN
                    lo_d = bus_rdata_i;
                    if (cross_q) begin
                        // Second beat issued on the same edge for back-to-back beats.
                        state_d     = BEAT1;
                        bus_addr_d  = bus_addr_q + XLEN'(4);
                        bus_wstrb_d = 4'(({4'b0000, mask(size_q)} << off_q) >> 4);
                        bus_wdata_d = data_q >> {3'd4 - {1'b0, off_q}, 3'b000};
                    end else
`endif
                    begin
                        state_d   = RESP;
                        bus_req_d = 1'b0;
                        if (!we_q) rdata_d = extract({{XLEN{1'b0}}, bus_rdata_i}, off_q, size_q);
                    end
                end
            end
`ifdef MISALIGN_SPLIT_EN
            BEAT1: begin
                if (bus_ack_i) begin
                    state_d   = RESP;
                    bus_req_d = 1'b0;
                    if (!we_q) rdata_d = extract({bus_rdata_i, lo_q}, off_q, size_q);
                end
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            off_q       <= '0;
            size_q      <= '0;
            we_q        <= 1'b0;
            rdata_q     <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
`ifdef MISALIGN_SPLIT_EN
            data_q      <= '0;
            lo_q        <= '0;
            cross_q     <= 1'b0;
`else
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            size_q      <= size_d;
            we_q        <= we_d;
            rdata_q     <= rdata_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
`ifdef MISALIGN_SPLIT_EN
            data_q      <= data_d;
            lo_q        <= lo_d;
            cross_q     <= cross_d;
`else
            err_q       <= err_d;
`endif
        end
    end

    assign mem_data_in_o     = rdata_q;
    assign mem_read_ready_o  = (state_q == RESP) && !we_q;
    assign mem_write_ready_o = (state_q == RESP) && we_q;
`ifdef MISALIGN_SPLIT_EN
    assign mem_misalign_o    = 1'b0;
`else
    assign mem_misalign_o    = (state_q == RESP) && err_q;
`endif
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_wstrb_o = bus_wstrb_q;

endmodule
